// File: rtl/arb_grant_holder.sv
// arb_grant_holder: turns a one-hot arbiter grant into a registered, held bus ownership.
//   clk_i        - clock, all state updates on the rising edge
//   rst_ni       - asynchronous active-low reset
//   req_i        - raw request vector (same one feeding the arbiter), used to detect release
//   arb_gnt_i    - arbiter one-hot grant
//   arb_valid_i  - arbiter valid
//   owner_gnt_o  - registered one-hot owner, zero when nobody owns the bus
//   owner_id_o   - binary index of the owner, zero when not busy
//   busy_o       - high while an ownership is held
//   hold_cnt_o   - completed ownership cycles, saturating at MAX_HOLD
//   timeout_o    - one-cycle pulse on forced revocation
//   gnt_err_o    - one-cycle pulse on a valid but non-one-hot grant while idle
// Define ARB_GRANT_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module arb_grant_holder #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  localparam int IW      = $clog2(N),
  localparam int CW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  arb_gnt_i,
  input  logic          arb_valid_i,
  output logic [N-1:0]  owner_gnt_o,
  output logic [IW-1:0] owner_id_o,
  output logic          busy_o,
  output logic [CW-1:0] hold_cnt_o,
  output logic          timeout_o,
  output logic          gnt_err_o
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;
  state_e        state_q, state_d;
  logic [N-1:0]  owner_gnt_q, owner_gnt_d;
  logic [IW-1:0] owner_id_q, owner_id_d, gnt_idx;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d, gnt_err_q, gnt_err_d;
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) if (arb_gnt_i[i]) gnt_idx = IW'(i);
  end
  always_comb begin
    state_d     = state_q;
    owner_gnt_d = owner_gnt_q;
    owner_id_d  = owner_id_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    gnt_err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (arb_valid_i) begin
        if ($onehot(arb_gnt_i)) begin
          state_d     = HOLD;
          owner_gnt_d = arb_gnt_i;
          owner_id_d  = gnt_idx;
          hold_cnt_d  = '0;
        end else gnt_err_d = 1'b1;
      end
      HOLD: begin
        // Owner release wins over a coincident timeout, so it is tested first.
        if (!req_i[owner_id_q]) state_d = GAP;
`ifdef ARB_GRANT_TIMEOUT_EN
        else if (hold_cnt_q == CW'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end
`endif
        else if (hold_cnt_q != CW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + CW'(1);
        if (state_d == GAP) begin
          owner_gnt_d = '0;
          owner_id_d  = '0;
          hold_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_gnt_q <= '0;
      owner_id_q  <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      gnt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_gnt_q <= owner_gnt_d;
      owner_id_q  <= owner_id_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
      gnt_err_q   <= gnt_err_d;
    end
  end
  assign owner_gnt_o = owner_gnt_q;
  assign owner_id_o  = owner_id_q;
  assign busy_o      = state_q == HOLD;
  assign hold_cnt_o  = hold_cnt_q;
  assign timeout_o   = timeout_q;
  assign gnt_err_o   = gnt_err_q;
endmodule
